move_link_tx: RTL and testbench
===============================

// Module: move_link_tx
// PURPOSE
//  Reliable-send stage between game_fsm and the UART tx serializer.
//  - Queues each local move byte presented on game_fsm's tx_ready pulse.
//  - Fires the tx trigger with the queued byte, then waits for an ACK byte from the peer over rx.
//  - Retransmits on timeout and raises a sticky failure flag after MAX_RETRY unanswered retries.
// PARAMETERS
//  PKT_LEN      8          width of a move byte / UART packet
//  DEPTH        4          move FIFO entries (power of 2, >=2)
//  BYTE_CLKS    67_710     clocks tx needs to shift one frame (10 bits * 6771 @65MHz/9600)
//  ACK_TIMEOUT  6_500_000  clocks to wait for ACK after frame end (100 ms @65MHz)
//  MAX_RETRY    3          retransmissions allowed before failure
//  ACK_BYTE     8'hAA      rx byte value that acknowledges the outstanding move
// PORTS
//  clk_in           in   1        system clock (65 MHz)
//  rst_in           in   1        synchronous, active-high reset
//  move_valid_in    in   1        1-cycle pulse: move_in is a new move to send
//  move_in          in   PKT_LEN  move byte from game_fsm/user_io
//  rx_ready_in      in   1        1-cycle pulse from rx: rx_data_in is valid
//  rx_data_in       in   PKT_LEN  received byte
//  trigger_out      out  1        1-cycle pulse to tx trigger_in
//  data_out         out  PKT_LEN  byte to tx val_in; held from SEND until pop
//  busy_out         out  1        1 when state != IDLE or FIFO non-empty
//  full_out         out  1        FIFO holds DEPTH entries
//  overflow_out     out  1        sticky: a push was dropped because FIFO full
//  link_fail_out    out  1        sticky: MAX_RETRY retries exhausted
//  retry_count_out  out  2        retries spent on current head move
// BEHAVIOUR
//  Reset (rst_in=1 at posedge): state=IDLE; FIFO empty; both timers=0; retry=0.
//   All outputs 0, including data_out. Reset mid-frame aborts silently; no trigger follows.
//  FIFO:
//   - Push on move_valid_in && !full_out. Push when full is dropped and sets overflow_out.
//   - Pop only on ACK (see WAIT_ACK). Push+pop in the same cycle: count unchanged.
//   - Pointers wrap modulo DEPTH. Count register is $clog2(DEPTH+1) bits.
//   - data_out = head entry; combinational from storage, stable while the entry is head.
//  FSM states: IDLE, SEND, WAIT_TX, WAIT_ACK, FAIL.
//   IDLE:     FIFO non-empty -> SEND on the next cycle.
//   SEND:     trigger_out=1 for exactly this cycle; tx_timer<=BYTE_CLKS-1; -> WAIT_TX.
//   WAIT_TX:  tx_timer decrements each cycle. At 0: ack_timer<=ACK_TIMEOUT-1; -> WAIT_ACK.
//             rx bytes are ignored in this state.
//   WAIT_ACK: rx_ready_in && rx_data_in==ACK_BYTE -> pop; retry<=0; -> IDLE.
//             Other rx bytes are ignored.
//             ack_timer==0 with no ACK:
//               retry<MAX_RETRY -> retry++, -> SEND.
//               retry==MAX_RETRY -> -> FAIL.
//             ACK and timeout in the same cycle: ACK wins.
//   FAIL:     link_fail_out=1 and no triggers until rst_in. FIFO still accepts pushes until full.
//  Latency: push into an empty FIFO in IDLE (cycle N) -> trigger_out at N+2.
//  Back-to-back moves:
//   - Next SEND is no earlier than 2 cycles after the ACK pop.
//   - At most one trigger_out per BYTE_CLKS+1 cycles.
//  Timers are down-counters sized $clog2(max(BYTE_CLKS,ACK_TIMEOUT)+1). No wrap; they hold at 0.
// TESTING  (bench params: DEPTH=4, BYTE_CLKS=10, ACK_TIMEOUT=50, MAX_RETRY=2)
//  - Push 8'h35 @cyc0, ACK 8'hAA 5 cyc after WAIT_ACK entry.
//      -> trigger_out 1 cycle @cyc2 with data_out=8'h35.
//      -> pop; busy_out=0; exactly 1 trigger.
//  - Push 8'h12, never ACK.
//      -> 3 triggers total, spaced 10+50+1 cycles.
//      -> retry_count_out 0,1,2, then link_fail_out=1 held; no 4th trigger.
//  - Push 5 moves 1..5 in consecutive cycles.
//      -> full_out after 4th; overflow_out=1.
//      -> ACKs yield data_out sequence 1,2,3,4 and FIFO empty.
//  - In WAIT_ACK, rx 8'h07 then 8'hAA.
//      -> 8'h07 ignored; pop occurs on 8'hAA.
//  - ACK and timer expiry in the same cycle.
//      -> pop, no retransmit, retry_count_out=0.
//  - rst_in pulsed during WAIT_TX with 2 queued.
//      -> all outputs 0 next cycle; no trigger until a new push.

Source files
------------

// File: rtl/move_link_tx.sv
// rtl/move_link_tx.sv - reliable move sender: move FIFO, tx trigger, ACK wait, timed retransmit, sticky failure
module move_link_tx #(
    parameter int                 PKT_LEN     = 8,
    parameter int                 DEPTH       = 4,
    parameter int                 BYTE_CLKS   = 67_710,
    parameter int                 ACK_TIMEOUT = 6_500_000,
    parameter int                 MAX_RETRY   = 3,
    parameter logic [PKT_LEN-1:0] ACK_BYTE    = 8'hAA
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               move_valid_in,
    input  logic [PKT_LEN-1:0] move_in,
    input  logic               rx_ready_in,
    input  logic [PKT_LEN-1:0] rx_data_in,
    output logic               trigger_out,
    output logic [PKT_LEN-1:0] data_out,
    output logic               busy_out,
    output logic               full_out,
    output logic               overflow_out,
    output logic               link_fail_out,
    output logic [1:0]         retry_count_out
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int TMAX = (BYTE_CLKS > ACK_TIMEOUT) ? BYTE_CLKS : ACK_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TX_LOAD  = TW'(BYTE_CLKS - 1);
    localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_TIMEOUT - 1);
    localparam logic [1:0]    MAX_R    = 2'(MAX_RETRY);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_ACK, FAIL} state_t;

    state_t             state;
    logic [PKT_LEN-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [TW-1:0]      tx_timer;
    logic [TW-1:0]      ack_timer;
    logic [1:0]         retry;
    logic               push;
    logic               pop;

    assign full_out        = (count == FULL_CNT);
    assign push            = move_valid_in && !full_out;
    assign pop             = (state == WAIT_ACK) && rx_ready_in && (rx_data_in == ACK_BYTE);
    assign busy_out        = (state != IDLE) || (count != '0);
    // Gate on empty so stale storage never leaks out after reset.
    assign data_out        = (count != '0) ? mem[rd_ptr] : '0;
    assign retry_count_out = retry;

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= move_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (move_valid_in && full_out) begin
                overflow_out <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            tx_timer      <= '0;
            ack_timer     <= '0;
            retry         <= '0;
            trigger_out   <= 1'b0;
            link_fail_out <= 1'b0;
        end else begin
            trigger_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state       <= SEND;
                        trigger_out <= 1'b1;
                    end
                end
                SEND: begin
                    tx_timer <= TX_LOAD;
                    state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_timer == '0) begin
                        ack_timer <= ACK_LOAD;
                        state     <= WAIT_ACK;
                    end else begin
                        tx_timer <= tx_timer - 1'b1;
                    end
                end
                WAIT_ACK: begin
                    // An ACK arriving on the expiry cycle still counts.
                    if (pop) begin
                        retry <= '0;
                        state <= IDLE;
                    end else if (ack_timer == '0) begin
                        if (retry < MAX_R) begin
                            retry       <= retry + 1'b1;
                            state       <= SEND;
                            trigger_out <= 1'b1;
                        end else begin
                            state         <= FAIL;
                            link_fail_out <= 1'b1;
                        end
                    end else begin
                        ack_timer <= ack_timer - 1'b1;
                    end
                end
                FAIL: begin
                    link_fail_out <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_link_tx.sv
// tb/tb_move_link_tx.sv - directed self-checking bench for move_link_tx
module tb_move_link_tx;

    logic       clk_in;
    logic       rst_in;
    logic       move_valid_in;
    logic [7:0] move_in;
    logic       rx_ready_in;
    logic [7:0] rx_data_in;
    logic       trigger_out;
    logic [7:0] data_out;
    logic       busy_out;
    logic       full_out;
    logic       overflow_out;
    logic       link_fail_out;
    logic [1:0] retry_count_out;

    int n_cmp;
    int n_err;
    int trig_cnt;
    int base;

    move_link_tx #(
        .PKT_LEN(8), .DEPTH(4), .BYTE_CLKS(10), .ACK_TIMEOUT(50),
        .MAX_RETRY(2), .ACK_BYTE(8'hAA)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .move_valid_in(move_valid_in), .move_in(move_in),
        .rx_ready_in(rx_ready_in), .rx_data_in(rx_data_in),
        .trigger_out(trigger_out), .data_out(data_out),
        .busy_out(busy_out), .full_out(full_out),
        .overflow_out(overflow_out), .link_fail_out(link_fail_out),
        .retry_count_out(retry_count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (trigger_out === 1'b1) trig_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick(2);
        rst_in = 1'b0;
    endtask

    task automatic push_one(input logic [7:0] v);
        move_valid_in = 1'b1;
        move_in       = v;
        tick(1);
        move_valid_in = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] v);
        rx_ready_in = 1'b1;
        rx_data_in  = v;
        tick(1);
        rx_ready_in = 1'b0;
    endtask

    task automatic wait_trigger(input int bound);
        int i;
        i = 0;
        while (trigger_out !== 1'b1 && i < bound) begin
            tick(1);
            i++;
        end
        chk("trigger_seen", {31'd0, trigger_out}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_err = 0; trig_cnt = 0;
        rst_in = 1'b1; move_valid_in = 1'b0; move_in = '0;
        rx_ready_in = 1'b0; rx_data_in = '0;

        // reset state
        do_reset();
        chk("rst_trigger", {31'd0, trigger_out}, 32'd0);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_full", {31'd0, full_out}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_out}, 32'd0);
        chk("rst_fail", {31'd0, link_fail_out}, 32'd0);
        chk("rst_retry", {30'd0, retry_count_out}, 32'd0);

        // single move, ACK 5 cycles into WAIT_ACK
        base = trig_cnt;
        push_one(8'h35);                                   // c1
        chk("t1_trig_c1", {31'd0, trigger_out}, 32'd0);
        chk("t1_busy_c1", {31'd0, busy_out}, 32'd1);
        tick(1);                                           // c2
        chk("t1_trig_c2", {31'd0, trigger_out}, 32'd1);
        chk("t1_data_c2", {24'd0, data_out}, 32'h35);
        tick(1);                                           // c3
        chk("t1_trig_c3", {31'd0, trigger_out}, 32'd0);
        tick(14);                                          // c17
        chk("t1_busy_c17", {31'd0, busy_out}, 32'd1);
        tick(1);                                           // c18
        rx_byte(8'hAA);                                    // c19
        chk("t1_busy_after_ack", {31'd0, busy_out}, 32'd0);
        tick(70);
        chk("t1_trig_count", trig_cnt - base, 32'd1);

        // never ACKed: 3 triggers spaced 61, then FAIL
        do_reset();
        base = trig_cnt;
        push_one(8'h12);                                   // c1
        tick(1);                                           // c2
        chk("t2_trig0", {31'd0, trigger_out}, 32'd1);
        chk("t2_retry0", {30'd0, retry_count_out}, 32'd0);
        chk("t2_data0", {24'd0, data_out}, 32'h12);
        tick(60);                                          // c62
        chk("t2_trig_c62", {31'd0, trigger_out}, 32'd0);
        tick(1);                                           // c63
        chk("t2_trig1", {31'd0, trigger_out}, 32'd1);
        chk("t2_retry1", {30'd0, retry_count_out}, 32'd1);
        tick(61);                                          // c124
        chk("t2_trig2", {31'd0, trigger_out}, 32'd1);
        chk("t2_retry2", {30'd0, retry_count_out}, 32'd2);
        tick(60);                                          // c184
        chk("t2_fail_c184", {31'd0, link_fail_out}, 32'd0);
        tick(1);                                           // c185
        chk("t2_fail_c185", {31'd0, link_fail_out}, 32'd1);
        tick(100);
        chk("t2_fail_held", {31'd0, link_fail_out}, 32'd1);
        chk("t2_trig_count", trig_cnt - base, 32'd3);

        // 5 back-to-back pushes into a 4-deep FIFO
        do_reset();
        for (int i = 0; i < 5; i++) begin
            move_valid_in = 1'b1;
            move_in       = 8'(i + 1);
            tick(1);
            if (i == 1) begin
                chk("t3_trig_c2", {31'd0, trigger_out}, 32'd1);
                chk("t3_data_c2", {24'd0, data_out}, 32'd1);
            end
            if (i == 3) begin
                chk("t3_full_c4", {31'd0, full_out}, 32'd1);
                chk("t3_ovf_c4", {31'd0, overflow_out}, 32'd0);
            end
        end
        move_valid_in = 1'b0;                              // c5
        chk("t3_ovf_c5", {31'd0, overflow_out}, 32'd1);
        chk("t3_full_c5", {31'd0, full_out}, 32'd1);
        tick(8);                                           // c13
        rx_byte(8'hAA);
        chk("t3_full_after_pop", {31'd0, full_out}, 32'd0);
        for (int k = 2; k <= 4; k++) begin
            wait_trigger(20);
            chk("t3_data_seq", {24'd0, data_out}, 32'(k));
            tick(11);
            rx_byte(8'hAA);
        end
        chk("t3_busy_end", {31'd0, busy_out}, 32'd0);
        chk("t3_ovf_sticky", {31'd0, overflow_out}, 32'd1);

        // non-ACK byte ignored; ACK during WAIT_TX ignored
        do_reset();
        base = trig_cnt;
        push_one(8'h5A);
        wait_trigger(5);                                   // c2
        tick(5);                                           // c7 WAIT_TX
        rx_byte(8'hAA);                                    // c8
        tick(5);                                           // c13 WAIT_ACK entry
        rx_byte(8'h07);                                    // c14
        chk("t4_busy_after_07", {31'd0, busy_out}, 32'd1);
        chk("t4_data_after_07", {24'd0, data_out}, 32'h5A);
        rx_byte(8'hAA);                                    // c15
        chk("t4_busy_after_aa", {31'd0, busy_out}, 32'd0);
        tick(70);
        chk("t4_trig_count", trig_cnt - base, 32'd1);

        // ACK on the timeout cycle
        do_reset();
        base = trig_cnt;
        push_one(8'h44);
        wait_trigger(5);                                   // c2
        tick(60);                                          // c62, ack_timer == 0
        rx_byte(8'hAA);                                    // c63
        chk("t5_no_retx", {31'd0, trigger_out}, 32'd0);
        chk("t5_busy", {31'd0, busy_out}, 32'd0);
        chk("t5_retry", {30'd0, retry_count_out}, 32'd0);
        tick(70);
        chk("t5_trig_count", trig_cnt - base, 32'd1);

        // reset during WAIT_TX with two queued
        do_reset();
        base = trig_cnt;
        push_one(8'h21);
        push_one(8'h22);                                   // c2
        chk("t6_trig_c2", {31'd0, trigger_out}, 32'd1);
        tick(4);                                           // c6 WAIT_TX
        rst_in = 1'b1;
        tick(1);
        rst_in = 1'b0;
        chk("t6_busy", {31'd0, busy_out}, 32'd0);
        chk("t6_data", {24'd0, data_out}, 32'd0);
        chk("t6_full", {31'd0, full_out}, 32'd0);
        chk("t6_trig", {31'd0, trigger_out}, 32'd0);
        chk("t6_retry", {30'd0, retry_count_out}, 32'd0);
        tick(100);
        chk("t6_trig_count", trig_cnt - base, 32'd1);
        push_one(8'h33);
        wait_trigger(5);
        chk("t6_new_data", {24'd0, data_out}, 32'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
